// File: rtl/ipml_fifo_pkg.sv
// Shared sizing helpers and threshold defaults for the ipml prefetch FIFO family.
package ipml_fifo_pkg;

    localparam int AE_DEFAULT = 4;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

    function automatic int ptr_width(input int depth_width);
        return depth_width + 1;
    endfunction

    // Level counter holds memory depth plus up to 4 prefetch entries.
    function automatic int lvl_width(input int depth_width);
        return depth_width + 2;
    endfunction

    function automatic int af_default(input int depth_width);
        return (1 << depth_width) - 4;
    endfunction

endpackage

// File: rtl/ipml_prefetch_buf.sv
// Small shift-style register FIFO; entry 0 is always the head word.
module ipml_prefetch_buf
    import ipml_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PF_DEPTH   = 2,
    parameter int CW         = clog2(PF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_vld,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  out_rdy,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_vld,
    output logic [CW-1:0]         cnt
);

    logic [PF_DEPTH-1:0][DATA_WIDTH-1:0] ent_q, ent_d;
    logic [CW-1:0]                       cnt_q, cnt_d;
    logic [CW-1:0]                       widx;
    logic                                pop;

    assign pop  = out_rdy & (cnt_q != '0);
    // A pop shifts everything down first, so the landing slot moves with it.
    assign widx = pop ? (cnt_q - CW'(1)) : cnt_q;

    always_comb begin
        ent_d = ent_q;
        if (pop) begin
            for (int i = 0; i < PF_DEPTH - 1; i++) ent_d[i] = ent_q[i+1];
            ent_d[PF_DEPTH-1] = '0;
        end
        if (in_vld) begin
            for (int i = 0; i < PF_DEPTH; i++) begin
                if (CW'(i) == widx) ent_d[i] = in_data;
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (in_vld & ~pop)      cnt_d = cnt_q + CW'(1);
        else if (pop & ~in_vld) cnt_d = cnt_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q <= '0;
            cnt_q <= '0;
        end else begin
            ent_q <= ent_d;
            cnt_q <= cnt_d;
        end
    end

    assign out_data = ent_q[0];
    assign out_vld  = (cnt_q != '0);
    assign cnt      = cnt_q;

endmodule

// File: rtl/ipml_prefetch_sync_fifo_v2_0.sv
// First-word-fall-through sync FIFO: memory plus prefetch buffer, water level and AF/AE flags.
// Define IPML_FIFO_ERR_FLAG_EN to add sticky overflow/underflow flags with err_clr.
module ipml_prefetch_sync_fifo_v2_0
    import ipml_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WIDTH = 10,
    parameter int PF_DEPTH    = 2,
    parameter int AF_THRESH   = af_default(DEPTH_WIDTH),
    parameter int AE_THRESH   = AE_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_en,
    output logic                   wr_vld,
    output logic [DATA_WIDTH-1:0]  rd_data,
    input  logic                   rd_en,
    output logic                   rd_vld,
    output logic [DEPTH_WIDTH+1:0] water_level,
    output logic                   almost_full,
    output logic                   almost_empty
`ifdef IPML_FIFO_ERR_FLAG_EN
    ,
    input  logic                   err_clr,
    output logic                   overflow,
    output logic                   underflow
`endif
);

    localparam int PW    = ptr_width(DEPTH_WIDTH);
    localparam int LW    = lvl_width(DEPTH_WIDTH);
    localparam int DEPTH = 1 << DEPTH_WIDTH;
    localparam int CW    = clog2(PF_DEPTH + 1);
    localparam logic [LW-1:0] AF_LVL = LW'(AF_THRESH);
    localparam logic [LW-1:0] AE_LVL = LW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         wl_q, wl_d;
    logic                  af_q, ae_q;
    logic                  mem_empty, mem_full;
    logic                  push, pop, fetch;
    logic [CW-1:0]         pf_cnt;
    logic [DATA_WIDTH-1:0] mem_rdata;

    assign mem_empty = (wr_ptr_q == rd_ptr_q);
    assign mem_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                       (wr_ptr_q[DEPTH_WIDTH-1:0] == rd_ptr_q[DEPTH_WIDTH-1:0]);
    assign wr_vld    = ~mem_full;
    assign push      = wr_en & wr_vld;
    assign pop       = rd_en & rd_vld;

    // The memory read edge is the buffer's capture edge, so a fetch is never
    // outstanding when the next fetch is decided; only the buffer count matters.
    assign fetch     = ~mem_empty & ((pf_cnt < CW'(PF_DEPTH)) | pop);
    assign mem_rdata = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];

    assign wr_ptr_d  = push  ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    assign rd_ptr_d  = fetch ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data;
    end

    always_comb begin
        wl_d = wl_q;
        if (push & ~pop)      wl_d = wl_q + LW'(1);
        else if (pop & ~push) wl_d = wl_q - LW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            wl_q     <= '0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wl_q     <= wl_d;
            af_q     <= (wl_d >= AF_LVL);
            ae_q     <= (wl_d <= AE_LVL);
        end
    end

    ipml_prefetch_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .PF_DEPTH   (PF_DEPTH),
        .CW         (CW)
    ) u_pf (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_vld   (fetch),
        .in_data  (mem_rdata),
        .out_rdy  (pop),
        .out_data (rd_data),
        .out_vld  (rd_vld),
        .cnt      (pf_cnt)
    );

    assign water_level  = wl_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;

`ifdef IPML_FIFO_ERR_FLAG_EN
    logic ovf_q, udf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en & ~wr_vld) ovf_q <= 1'b1;
            else if (err_clr)    ovf_q <= 1'b0;
            if (rd_en & ~rd_vld) udf_q <= 1'b1;
            else if (err_clr)    udf_q <= 1'b0;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`endif

endmodule

// File: tb/tb_ipml_prefetch_sync_fifo_v2_0.sv
// Directed bench for the v2 prefetch FIFO (DEPTH_WIDTH=4, PF_DEPTH=2), vector table plus corner sequences.
module tb_ipml_prefetch_sync_fifo_v2_0;

    localparam int DW = 32;
    localparam int AW = 4;
    localparam int PF = 2;
    localparam int LW = AW + 2;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] wr_data;
    logic          wr_en;
    logic          wr_vld;
    logic [DW-1:0] rd_data;
    logic          rd_en;
    logic          rd_vld;
    logic [LW-1:0] water_level;
    logic          almost_full;
    logic          almost_empty;
`ifdef IPML_FIFO_ERR_FLAG_EN
    logic          err_clr;
    logic          overflow;
    logic          underflow;
`endif

    int checks = 0;
    int errors = 0;

    ipml_prefetch_sync_fifo_v2_0 #(
        .DATA_WIDTH  (DW),
        .DEPTH_WIDTH (AW),
        .PF_DEPTH    (PF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .wr_vld       (wr_vld),
        .rd_data      (rd_data),
        .rd_en        (rd_en),
        .rd_vld       (rd_vld),
        .water_level  (water_level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
`ifdef IPML_FIFO_ERR_FLAG_EN
        ,
        .err_clr      (err_clr),
        .overflow     (overflow),
        .underflow    (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr_en;
        logic [DW-1:0] wr_data;
        logic          rd_en;
        logic          e_vld;
        logic [DW-1:0] e_data;
        logic [LW-1:0] e_wl;
        logic          e_wrvld;
        logic          e_af;
        logic          e_ae;
    } vec_t;

    vec_t vt [16];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
`ifdef IPML_FIFO_ERR_FLAG_EN
        err_clr = 1'b0;
`endif
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rcv;
        int sent;

        //          wr  data          rd  vld edata         wl  wrv af ae
        vt[0]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd0, 1'b1, 1'b0, 1'b1};
        vt[1]  = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 32'h0,        6'd0, 1'b1, 1'b0, 1'b1};
        vt[2]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd1, 1'b1, 1'b0, 1'b1};
        vt[3]  = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hA5A5A5A5, 6'd1, 1'b1, 1'b0, 1'b1};
        vt[4]  = '{1'b1, 32'h11,       1'b0, 1'b1, 32'hA5A5A5A5, 6'd1, 1'b1, 1'b0, 1'b1};
        vt[5]  = '{1'b1, 32'h22,       1'b0, 1'b1, 32'hA5A5A5A5, 6'd2, 1'b1, 1'b0, 1'b1};
        vt[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'hA5A5A5A5, 6'd3, 1'b1, 1'b0, 1'b1};
        vt[7]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h11,       6'd2, 1'b1, 1'b0, 1'b1};
        vt[8]  = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h22,       6'd1, 1'b1, 1'b0, 1'b1};
        vt[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd0, 1'b1, 1'b0, 1'b1};
        vt[10] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        6'd0, 1'b1, 1'b0, 1'b1};
        vt[11] = '{1'b1, 32'h33,       1'b1, 1'b0, 32'h0,        6'd0, 1'b1, 1'b0, 1'b1};
        vt[12] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd1, 1'b1, 1'b0, 1'b1};
        vt[13] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h33,       6'd1, 1'b1, 1'b0, 1'b1};
        vt[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h33,       6'd1, 1'b1, 1'b0, 1'b1};
        vt[15] = '{1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        6'd0, 1'b1, 1'b0, 1'b1};

        // Reset state and single-word latency / basic ordering.
        do_reset();
        @(negedge clk);
        chk("reset_rd_data", rd_data, 0);
        for (int i = 0; i < 16; i++) begin
            wr_en   = vt[i].wr_en;
            wr_data = vt[i].wr_data;
            rd_en   = vt[i].rd_en;
            @(negedge clk);
            chk($sformatf("v%0d_rd_vld", i), rd_vld, vt[i].e_vld);
            if (vt[i].e_vld) chk($sformatf("v%0d_rd_data", i), rd_data, vt[i].e_data);
            chk($sformatf("v%0d_wl", i), water_level, vt[i].e_wl);
            chk($sformatf("v%0d_wr_vld", i), wr_vld, vt[i].e_wrvld);
            chk($sformatf("v%0d_af", i), almost_full, vt[i].e_af);
            chk($sformatf("v%0d_ae", i), almost_empty, vt[i].e_ae);
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;

        // Fill to 2^4 + 2 words, overflow attempt ignored, then drain in order.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h100 + i;
            @(negedge clk);
            chk($sformatf("fill_wr_vld_%0d", i), wr_vld, 1);
            tick();
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("full_wr_vld", wr_vld, 0);
        chk("full_wl", water_level, 18);
        chk("full_af", almost_full, 1);
        chk("full_ae", almost_empty, 0);
        wr_en   = 1'b1;
        wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("full_ignore_wl", water_level, 18);
        chk("full_ignore_wr_vld", wr_vld, 0);
        tick();
        rd_en = 1'b1;
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            chk($sformatf("drain18_vld_%0d", k), rd_vld, 1);
            chk($sformatf("drain18_data_%0d", k), rd_data, 32'h100 + k);
            tick();
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("drain18_empty_vld", rd_vld, 0);
        chk("drain18_empty_wl", water_level, 0);

        // Ten words, back-to-back pops without bubbles.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h200 + i;
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t3_wl10", water_level, 10);
        chk("t3_ae0", almost_empty, 0);
        chk("t3_af0", almost_full, 0);
        tick();
        rd_en = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("t3_vld_%0d", k), rd_vld, 1);
            chk($sformatf("t3_data_%0d", k), rd_data, 32'h200 + k);
            tick();
        end
        rd_en = 1'b0;
        @(negedge clk);
        chk("t3_end_vld", rd_vld, 0);
        chk("t3_end_wl", water_level, 0);
        chk("t3_end_ae", almost_empty, 1);
        tick();

        // Streaming 3 x 16 words through with pointer wrap.
        do_reset();
        rcv  = 0;
        sent = 0;
        rd_en = 1'b1;
        for (int c = 0; c < 200 && rcv < 48; c++) begin
            wr_en   = (sent < 48);
            wr_data = 32'h1000 + sent;
            @(negedge clk);
            if (wr_en) chk($sformatf("t4_wr_vld_%0d", c), wr_vld, 1);
            if (c >= 2 && c <= 48) chk($sformatf("t4_wl_%0d", c), water_level, 2);
            if (c >= 2 && c <= 49) chk($sformatf("t4_nobubble_%0d", c), rd_vld, 1);
            if (rd_vld) begin
                chk($sformatf("t4_data_%0d", rcv), rd_data, 32'h1000 + rcv);
                rcv++;
            end
            if (wr_en && wr_vld) sent++;
            tick();
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
        chk("t4_received", rcv, 48);
        @(negedge clk);
        chk("t4_end_wl", water_level, 0);
        tick();

        // Asynchronous reset while holding 7 words.
        do_reset();
        for (int i = 0; i < 7; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h300 + i;
            tick();
        end
        wr_en = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("t5_pre_wl", water_level, 7);
        chk("t5_pre_vld", rd_vld, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_rst_vld", rd_vld, 0);
        chk("t5_rst_wl", water_level, 0);
        chk("t5_rst_wr_vld", wr_vld, 1);
        chk("t5_rst_ae", almost_empty, 1);
        chk("t5_rst_data", rd_data, 0);
        tick();
        rst_n = 1'b1;
        wr_en   = 1'b1;
        wr_data = 32'h5A5A5A5A;
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("t5_post_t1_vld", rd_vld, 0);
        tick();
        @(negedge clk);
        chk("t5_post_vld", rd_vld, 1);
        chk("t5_post_data", rd_data, 32'h5A5A5A5A);
        chk("t5_post_wl", water_level, 1);
        tick();

`ifdef IPML_FIFO_ERR_FLAG_EN
        do_reset();
        @(negedge clk);
        chk("t6_reset_udf", underflow, 0);
        chk("t6_reset_ovf", overflow, 0);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        @(negedge clk);
        chk("t6_udf_set", underflow, 1);
        tick();
        @(negedge clk);
        chk("t6_udf_held", underflow, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        @(negedge clk);
        chk("t6_udf_clr", underflow, 0);
        chk("t6_ovf_idle", overflow, 0);
        tick();
        for (int i = 0; i < 18; i++) begin
            wr_en   = 1'b1;
            wr_data = 32'h400 + i;
            tick();
        end
        @(negedge clk);
        chk("t6_ovf_before", overflow, 0);
        tick();
        wr_en = 1'b0;
        @(negedge clk);
        chk("t6_ovf_set", overflow, 1);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
